// File: rtl/hls_loop_component.sv
// Call/return accumulate-loop component: each call computes a * n by repeated
// addition and queues the result in an in-order show-ahead return FIFO.
module hls_loop_component #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 8,
  parameter int RET_W     = 32,
  parameter int RET_DEPTH = 4,
  localparam int CW = $clog2(RET_DEPTH + 1),
  localparam int PW = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  input  logic [DATA_W-1:0] arg_a,
  input  logic [CNT_W-1:0]  arg_n,
  output logic              done,
  input  logic              stall,
  output logic [RET_W-1:0]  returndata,
  output logic [CW:0]       pending
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [RET_W-1:0]   a_r;
  logic [RET_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [RET_W-1:0]   mem [RET_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      fifo_count;
  logic               accept;
  logic               push;
  logic               pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(RET_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO blocks new calls, which is what makes overflow impossible.
  assign busy       = reset || (state == RUN) || (fifo_count == CW'(RET_DEPTH));
  assign accept     = start && !busy;
  assign push       = (state == RUN) && (cnt == '0);
  assign done       = (fifo_count != '0);
  assign pop        = done && !stall;
  assign returndata = done ? mem[rd_ptr] : '0;
  assign pending    = {1'b0, fifo_count} + {{CW{1'b0}}, (state == RUN)};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      a_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= RET_W'(arg_a);
            cnt   <= arg_n;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            acc <= acc + a_r;
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= acc;
    end
  end

  // Push and pop in the same cycle leave the count alone; pointers move independently.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_loop_component.sv
// Self-checking bench for hls_loop_component: directed scenarios plus a
// randomized run against a cycle-level reference model of call/return timing.
module tb_hls_loop_component;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic [31:0] arg_a;
  logic [7:0]  arg_n;
  logic        done;
  logic        stall;
  logic [31:0] returndata;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;

  hls_loop_component #(
    .DATA_W(32), .CNT_W(8), .RET_W(32), .RET_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy),
    .arg_a(arg_a), .arg_n(arg_n), .done(done), .stall(stall),
    .returndata(returndata), .pending(pending)
  );

  always #5 clock = ~clock;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; arg_a = 32'd5; arg_n = 8'd1; stall = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy0 got=%b want=1", busy); end
    tick();
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending got=%0d want=0", pending); end
    checks++;
    if (returndata !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", returndata); end
    tick();
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b want=0", busy); end
    checks++;
    if (pending !== 4'd0) begin errors++; $display("FAIL reset_start_ignored pending got=%0d want=0", pending); end
  endtask

  // Issues one call and checks busy/done/returndata/pending for a window after it.
  task automatic run_call(input string name, input logic [31:0] a, input logic [7:0] n,
                          input logic [31:0] expv);
    int dk;
    dk = int'(n) + 2;
    tick();
    start = 1'b1; arg_a = a; arg_n = n; stall = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_accept_busy got=%b want=0", name, busy); end
    tick();
    start = 1'b0; arg_a = $urandom;
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clock);
      checks++;
      if (busy !== (k < dk)) begin errors++; $display("FAIL %s_busy k=%0d got=%b want=%b", name, k, busy, (k < dk)); end
      checks++;
      if (done !== (k == dk)) begin errors++; $display("FAIL %s_done k=%0d got=%b want=%b", name, k, done, (k == dk)); end
      checks++;
      if (pending !== ((k <= dk) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL %s_pending k=%0d got=%0d want=%0d", name, k, pending, (k <= dk) ? 1 : 0);
      end
      if (k == dk) begin
        checks++;
        if (returndata !== expv) begin errors++; $display("FAIL %s_data got=%h want=%h", name, returndata, expv); end
      end
      tick();
    end
  endtask

  task automatic test_basic();
    run_call("basic", 32'd5, 8'd3, 32'd15);
  endtask

  task automatic test_zero_iter();
    run_call("zero", 32'd7, 8'd0, 32'd0);
  endtask

  task automatic test_wrap();
    run_call("wrap", 32'hFFFF_FFFF, 8'd2, 32'hFFFF_FFFE);
  endtask

  task automatic test_backpressure();
    tick();
    for (int c = 0; c <= 21; c++) begin
      stall = (c < 16);
      start = (c < 18);
      arg_n = 8'd1;
      arg_a = (c < 12) ? 32'(c / 3 + 1) : 32'd5;
      @(negedge clock);
      if (c == 0 || c == 3 || c == 6 || c == 9 || c == 17) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_accept_busy c=%0d got=%b want=0", c, busy); end
      end
      if (c >= 12 && c <= 15) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_full_busy c=%0d got=%b want=1", c, busy); end
        checks++;
        if (pending !== 4'd4) begin errors++; $display("FAIL bp_pending c=%0d got=%0d want=4", c, pending); end
        checks++;
        if (done !== 1'b1 || returndata !== 32'd1) begin
          errors++; $display("FAIL bp_stalled_head c=%0d got=%b/%0d want=1/1", c, done, returndata);
        end
      end
      if (c == 16) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy16 got=%b want=1", busy); end
      end
      if (c >= 16 && c <= 20) begin
        checks++;
        if (done !== 1'b1 || returndata !== ((c == 20) ? 32'd5 : 32'(c - 15))) begin
          errors++; $display("FAIL bp_return c=%0d got=%b/%0d want=1/%0d", c, done, returndata, (c == 20) ? 5 : c - 15);
        end
      end
      if (c == 21) begin
        checks++;
        if (done !== 1'b0 || pending !== 4'd0) begin
          errors++; $display("FAIL bp_drained got=%b/%0d want=0/0", done, pending);
        end
      end
      tick();
    end
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic test_ignored_start();
    int ndone;
    ndone = 0;
    start = 1'b1; arg_a = 32'd2; arg_n = 8'd4; stall = 1'b0;
    @(negedge clock);
    tick();
    for (int k = 1; k <= 10; k++) begin
      start = (k == 2);
      arg_a = 32'd9;
      arg_n = 8'd0;
      @(negedge clock);
      checks++;
      if (pending > 4'd1) begin errors++; $display("FAIL ign_pending k=%0d got=%0d want<=1", k, pending); end
      if (done) begin
        ndone++;
        checks++;
        if (returndata !== 32'd8) begin errors++; $display("FAIL ign_data got=%0d want=8", returndata); end
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ign_return_count got=%0d want=1", ndone); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; arg_a = 32'd3; arg_n = 8'd10; stall = 1'b0;
    @(negedge clock);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      reset = (k == 4 || k == 5);
      @(negedge clock);
      if (k <= 3) begin
        checks++;
        if (busy !== 1'b1 || pending !== 4'd1) begin
          errors++; $display("FAIL rm_run k=%0d got=%b/%0d want=1/1", k, busy, pending);
        end
      end
      if (k == 4 || k == 5) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy k=%0d got=%b want=1", k, busy); end
      end
      if (k >= 5) begin
        checks++;
        if (done !== 1'b0 || pending !== 4'd0) begin
          errors++; $display("FAIL rm_discard k=%0d got=%b/%0d want=0/0", k, done, pending);
        end
      end
      tick();
    end
    reset = 1'b0;
    run_call("rm_after", 32'd1, 8'd1, 32'd1);
  endtask

  // Reference model: a call occupies n+1 cycles after acceptance, then its
  // product appears at the tail of a queue of at most DEPTH results.
  task automatic test_random();
    logic [31:0] q[$];
    int          runLeft;
    logic [31:0] runRes;
    logic        expBusy, expDone;
    logic [31:0] expData;
    logic [3:0]  expPend;
    runLeft = 0; runRes = '0;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      start = (cyc < 370) && ($urandom_range(0, 9) < 6);
      stall = (cyc < 370) && ($urandom_range(0, 3) == 0);
      arg_a = $urandom;
      arg_n = 8'($urandom_range(0, 5));
      expBusy = (runLeft > 0) || (q.size() == DEPTH);
      expDone = (q.size() != 0);
      expData = expDone ? q[0] : 32'd0;
      expPend = 4'(q.size() + ((runLeft > 0) ? 1 : 0));
      @(negedge clock);
      checks++;
      if (busy !== expBusy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, expBusy); end
      checks++;
      if (done !== expDone) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", cyc, done, expDone); end
      checks++;
      if (returndata !== expData) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, returndata, expData); end
      checks++;
      if (pending !== expPend) begin errors++; $display("FAIL rnd_pending cyc=%0d got=%0d want=%0d", cyc, pending, expPend); end
      if (expDone && !stall) void'(q.pop_front());
      if (runLeft == 1) q.push_back(runRes);
      if (runLeft > 0) runLeft--;
      if (start && !expBusy) begin
        runLeft = int'(arg_n) + 1;
        runRes  = 32'(longint'(arg_a) * longint'(arg_n));
      end
    end
    start = 1'b0; stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; arg_a = '0; arg_n = '0;
    test_reset();
    test_basic();
    test_zero_iter();
    test_wrap();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
